mlp_engine: RTL and testbench

Parametrised multi-layer perceptron engine. It accepts one input vector over a valid/ready stream and runs NUM_LAYERS fully-connected layers of DIM neurons each, using a single signed fixed-point MAC. Weights and biases are fetched from an external weight memory with fixed read latency. Hidden layers apply ReLU, and the final layer result streams out over valid/ready. It sits between the feature front-end and the classifier output logic.

---
 rtl/mlp_engine_if.sv | 31 +++
 rtl/mlp_engine.sv | 201 ++++++++++++++++++++
 tb/tb_mlp_engine.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mlp_engine_if.sv
// Stream, weight-memory and status bundle for mlp_engine: slave is the engine side, master the environment.
interface mlp_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 4,
  parameter int NUM_LAYERS = 3
);
  localparam int W_ADDR_WIDTH = $clog2(NUM_LAYERS * DIM * (DIM + 1));

  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_ready;
  logic                    w_rd_en;
  logic [W_ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic                    out_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/mlp_engine.sv
// Single-MAC fixed-point MLP: DIM+3 cycles per neuron, first output NUM_LAYERS*DIM*(DIM+3)+1 cycles after last input;
// output holds under out_ready low, input only accepted in LOAD. Define MLP_ROUND_EN for round-half-up requantisation.
module mlp_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int DIM        = 4,
  parameter int NUM_LAYERS = 3
) (
  input  logic         clk,
  input  logic         rst,
  mlp_engine_if.slave  bus
);
  localparam int W_ADDR_WIDTH = $clog2(NUM_LAYERS * DIM * (DIM + 1));
  localparam int ACC_W        = 2 * DATA_WIDTH + $clog2(DIM + 1);
  localparam int IDX_W        = $clog2(DIM);
  localparam int CNT_W        = $clog2(DIM + 1);
  localparam int LAYER_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int DW           = DATA_WIDTH;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIM - 1);
  localparam logic [CNT_W-1:0]   BIAS_K     = CNT_W'(DIM);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`ifdef MLP_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
`endif

  logic [2:0]           state;
  logic                 run;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     neuron;
  logic [LAYER_W-1:0]   layer;
  logic [CNT_W-1:0]     k;
  logic [CNT_W-1:0]     rd_k;
  logic                 rd_vld;
  logic                 src;
  logic signed [ACC_W-1:0] acc;
  logic                 out_valid_r;
  logic [DW-1:0]        out_data_r;
  logic                 out_last_r;
  logic                 done_r;

  logic signed [DW-1:0] act_buf [2][DIM];

  logic                 in_fire;
  logic signed [DW-1:0] act_rd;
  logic signed [2*DW-1:0] a_ext, w_ext, prod;
  logic signed [ACC_W-1:0] prod_ext, bias_term, acc_adj, acc_shr;
  logic [DW-1:0]        wr_val;

  assign bus.in_ready  = (state == S_LOAD) && run;
  assign bus.w_rd_en   = (state == S_MAC);
  assign bus.w_addr    = (state == S_MAC) ?
                         W_ADDR_WIDTH'(layer) * W_ADDR_WIDTH'(DIM * (DIM + 1)) +
                         W_ADDR_WIDTH'(neuron) * W_ADDR_WIDTH'(DIM + 1) +
                         W_ADDR_WIDTH'(k) : '0;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.done      = done_r;
  assign bus.busy      = !((state == S_LOAD) && (cnt == '0));

  assign in_fire = bus.in_valid && bus.in_ready;

  // Datapath for the word returned this cycle (issued one cycle earlier at index rd_k).
  always_comb begin
    act_rd    = act_buf[src][rd_k[IDX_W-1:0]];
    a_ext     = {{DW{act_rd[DW-1]}}, act_rd};
    w_ext     = {{DW{bus.w_data[DW-1]}}, bus.w_data};
    prod      = a_ext * w_ext;
    prod_ext  = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    bias_term = {{(ACC_W-DW){bus.w_data[DW-1]}}, bus.w_data} <<< FRAC_BITS;
  end

  // Requantise, saturate, and apply ReLU on hidden layers only.
  always_comb begin
    acc_adj = acc;
`ifdef MLP_ROUND_EN
    acc_adj = acc + ROUND_HALF;
`endif
    acc_shr = acc_adj >>> FRAC_BITS;
    if (acc_shr > SAT_MAX) begin
      wr_val = {1'b0, {(DW-1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      wr_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      wr_val = acc_shr[DW-1:0];
    end
    if ((layer != LAST_LAYER) && wr_val[DW-1]) begin
      wr_val = '0;
    end
  end

  // Activation buffers carry no reset: an aborted job simply leaves stale data behind.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      act_buf[src][cnt] <= bus.in_data;
    end
    if (state == S_WRITE) begin
      act_buf[~src][neuron] <= wr_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOAD;
      run         <= 1'b0;
      cnt         <= '0;
      neuron      <= '0;
      layer       <= '0;
      k           <= '0;
      rd_k        <= '0;
      rd_vld      <= 1'b0;
      src         <= 1'b0;
      acc         <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      run    <= 1'b1;
      done_r <= 1'b0;
      rd_vld <= (state == S_MAC);
      rd_k   <= k;

      if ((state == S_MAC) && (k == '0)) begin
        acc <= '0;
      end else if (rd_vld) begin
        acc <= acc + ((rd_k == BIAS_K) ? bias_term : prod_ext);
      end

      case (state)
        S_LOAD: begin
          if (in_fire) begin
            if (cnt == LAST_IDX) begin
              cnt    <= '0;
              layer  <= '0;
              neuron <= '0;
              k      <= '0;
              state  <= S_MAC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (k == BIAS_K) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          if (neuron != LAST_IDX) begin
            neuron <= neuron + 1'b1;
            state  <= S_MAC;
          end else if (layer != LAST_LAYER) begin
            layer  <= layer + 1'b1;
            neuron <= '0;
            src    <= ~src;
            state  <= S_MAC;
          end else begin
            cnt   <= '0;
            state <= S_OUT;
          end
        end
        S_OUT: begin
          // The first beat is registered one cycle after entry; later beats load on each handshake.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_data_r  <= act_buf[~src][cnt];
            out_last_r  <= (cnt == LAST_IDX);
          end else if (bus.out_ready) begin
            if (cnt == LAST_IDX) begin
              out_valid_r <= 1'b0;
              out_data_r  <= '0;
              out_last_r  <= 1'b0;
              cnt         <= '0;
              done_r      <= 1'b1;
              state       <= S_LOAD;
            end else begin
              cnt        <= cnt + 1'b1;
              out_data_r <= act_buf[~src][cnt + 1'b1];
              out_last_r <= ((cnt + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_engine.sv
// Directed self-checking bench for mlp_engine with DIM=2, NUM_LAYERS=2, Q8.8 data.
module tb_mlp_engine;
  localparam int DW  = 16;
  localparam int DIM = 2;
  localparam int NL  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mlp_engine_if #(.DATA_WIDTH(DW), .DIM(DIM), .NUM_LAYERS(NL)) bus ();

  mlp_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .DIM(DIM), .NUM_LAYERS(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] wmem [12];
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] o0, o1;
  logic [15:0] exp_rnd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_layer(input int l, input logic [15:0] w00, w01, b0, w10, w11, b1);
    wmem[l*6+0] = w00; wmem[l*6+1] = w01; wmem[l*6+2] = b0;
    wmem[l*6+3] = w10; wmem[l*6+4] = w11; wmem[l*6+5] = b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  0);
    check({tag, "_w_rd_en"},   32'(bus.w_rd_en),   0);
    check({tag, "_w_addr"},    32'(bus.w_addr),    0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},  32'(bus.out_data),  0);
    check({tag, "_out_last"},  32'(bus.out_last),  0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
  endtask

  task automatic send(input logic [15:0] d0, input logic [15:0] d1);
    logic [15:0] d [2];
    int t;
    d[0] = d0; d[1] = d1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      if (i == 0) check("busy_after_first", 32'(bus.busy), 1);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    t0 = cyc;
  endtask

  task automatic recv(output logic [15:0] r0, output logic [15:0] r1, input int stall);
    logic [15:0] got [2];
    int t;
    if (stall > 0) bus.out_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("latency", 32'(cyc - t0), 21);
    for (int b = 0; b < 2; b++) begin
      check("beat_valid", 32'(bus.out_valid), 1);
      check("beat_last",  32'(bus.out_last), (b == 1) ? 1 : 0);
      got[b] = bus.out_data;
      if (stall > 0 && b == 0) begin
        repeat (stall) begin
          @(negedge clk);
          check("stall_valid",    32'(bus.out_valid), 1);
          check("stall_data",     32'(bus.out_data),  32'(got[0]));
          check("stall_in_ready", 32'(bus.in_ready),  0);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_pulse",     32'(bus.done),      1);
    check("done_in_ready",  32'(bus.in_ready),  1);
    check("done_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("done_cleared", 32'(bus.done), 0);
    r0 = got[0];
    r1 = got[1];
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) wmem[i] = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 1);
    check("post_reset_busy",     32'(bus.busy),     0);

    // Identity: hidden -1.0 is cut by ReLU.
    set_layer(0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    set_layer(1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    send(16'h0100, 16'hFF00);
    recv(o0, o1, 0);
    check("ident_out0", 32'(o0), 32'h0100);
    check("ident_out1", 32'(o1), 32'h0000);

    // Final layer is linear: negative result survives.
    set_layer(1, 16'hFF00, 16'h0000, 16'h0080, 16'h0000, 16'hFF00, 16'h0080);
    send(16'h0100, 16'h0000);
    recv(o0, o1, 0);
    check("linear_out0", 32'(o0), 32'hFF80);
    check("linear_out1", 32'(o1), 32'h0080);

    // Positive saturation in the hidden layer.
    set_layer(0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000);
    set_layer(1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    send(16'h7FFF, 16'h7FFF);
    recv(o0, o1, 0);
    check("satpos_out0", 32'(o0), 32'h7FFF);
    check("satpos_out1", 32'(o1), 32'h7FFF);

    // Negative saturation then ReLU.
    set_layer(0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0000);
    send(16'h7FFF, 16'h7FFF);
    recv(o0, o1, 0);
    check("satneg_out0", 32'(o0), 32'h0000);
    check("satneg_out1", 32'(o1), 32'h0000);

    // Backpressure on the first beat.
    set_layer(0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000);
    send(16'h0100, 16'hFF00);
    recv(o0, o1, 5);
    check("bp_out0", 32'(o0), 32'h0100);
    check("bp_out1", 32'(o1), 32'h0000);

    // Reset during layer 1, neuron 0 MAC (k=1 -> address 7).
    send(16'h0100, 16'hFF00);
    repeat (12) @(negedge clk);
    check("mid_w_rd_en", 32'(bus.w_rd_en), 1);
    check("mid_w_addr",  32'(bus.w_addr),  7);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    send(16'h0100, 16'hFF00);
    recv(o0, o1, 0);
    check("after_rst_out0", 32'(o0), 32'h0100);
    check("after_rst_out1", 32'(o1), 32'h0000);

    // Requantisation rounding: 0.5 LSB either truncates or rounds up.
    set_layer(0, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000);
`ifdef MLP_ROUND_EN
    exp_rnd = 16'h0001;
`else
    exp_rnd = 16'h0000;
`endif
    send(16'h0001, 16'h0001);
    recv(o0, o1, 0);
    check("round_out0", 32'(o0), 32'(exp_rnd));
    check("round_out1", 32'(o1), 32'(exp_rnd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
